// File: rtl/pcie_audio_pkg.sv
// Shared definitions for the PCIe audio playback/capture blocks.
// - state_t : playback sequencer states (IDLE / PRIME / RUN)
// - PCM_W   : PCM sample width in bits
// - lanes() : number of samples carried in one FIFO word
package pcie_audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int PCM_W = 16;

  function automatic int lanes(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

endpackage

// File: rtl/pcie_rx_sample_unpacker.sv
// pcie_rx_sample_unpacker
// Playback-side unpacker: pops IN_WIDTH-bit words from a show-ahead FIFO filled
// by PCIe DMA, splits each word into IN_WIDTH/OUT_WIDTH PCM samples and emits
// one sample per sample-rate tick. Ticks that find no data produce silence and
// are counted as underruns.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              playback running; 0 stops popping and ignores ticks
//   flush               1-cycle pulse; drops held word, partial lanes, counters
//   in_vld, in_data     show-ahead FIFO head (valid flag + word)
//   in_rd_en            combinational pop strobe to the FIFO
//   smp_tick            1-cycle sample-rate strobe
//   out_vld, out_data   1-cycle sample pulse; out_data held between pulses
//   underrun            sticky underrun flag
//   under_cnt           saturating underrun count
module pcie_rx_sample_unpacker
  import pcie_audio_pkg::*;
#(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = PCM_W,
  parameter int LSB_FIRST = 1,
  parameter int UNDER_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 flush,
  input  logic                 in_vld,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_rd_en,
  input  logic                 smp_tick,
  output logic                 out_vld,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 underrun,
  output logic [UNDER_W-1:0]   under_cnt
);

  localparam int LANES = lanes(IN_WIDTH, OUT_WIDTH);
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int OFS_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  state_t               state;
  state_t               state_nxt;
  logic [IN_WIDTH-1:0]  hold_buf;
  logic                 buf_full;
  logic [IDX_W-1:0]     idx;
  logic                 last_lane;
  logic                 tick_take;
  logic                 tick_under;
  logic [OFS_W-1:0]     lane_lo;
  logic [OUT_WIDTH-1:0] lane_data;

  assign last_lane = (idx == LAST_IDX);

  // Ticks are only honoured while enabled and running; a tick in the cycle
  // enable drops is ignored just like ticks in IDLE.
  assign tick_take  = smp_tick & enable & (state == RUN) & buf_full;
  assign tick_under = smp_tick & enable & (state == RUN) & ~buf_full;

  // Refill either into an empty holding register or in the very cycle the
  // last lane is consumed, so consecutive words play back without a gap.
  assign in_rd_en = enable & ~flush & in_vld & (~buf_full | (tick_take & last_lane));

  // Lane offset: lane 0 sits at the bottom of the word when LSB_FIRST is set,
  // otherwise at the top.
  always_comb begin
    lane_lo = '0;
    if (LSB_FIRST != 0) begin
      lane_lo = OFS_W'(idx) * OFS_W'(OUT_WIDTH);
    end else begin
      lane_lo = OFS_W'(IN_WIDTH - OUT_WIDTH) - OFS_W'(idx) * OFS_W'(OUT_WIDTH);
    end
    lane_data = hold_buf[lane_lo +: OUT_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Disabling always parks in IDLE; flush restarts priming when still enabled.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable)   state_nxt = PRIME;
      PRIME:   if (buf_full) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (!enable) begin
      state_nxt = IDLE;
    end
    if (flush) begin
      state_nxt = enable ? PRIME : IDLE;
    end
  end

  // Flush wins over ticks and pops. A pop in the same cycle as the last-lane
  // tick overrides the buf_full clear, keeping the register full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_buf  <= '0;
      buf_full  <= 1'b0;
      idx       <= '0;
      out_vld   <= 1'b0;
      out_data  <= '0;
      underrun  <= 1'b0;
      under_cnt <= '0;
    end else if (flush) begin
      buf_full  <= 1'b0;
      idx       <= '0;
      out_vld   <= 1'b0;
      underrun  <= 1'b0;
      under_cnt <= '0;
    end else begin
      out_vld <= 1'b0;
      if (tick_take) begin
        out_data <= lane_data;
        out_vld  <= 1'b1;
        idx      <= idx + 1'b1;
        if (last_lane) begin
          buf_full <= 1'b0;
        end
      end else if (tick_under) begin
        out_data <= '0;
        out_vld  <= 1'b1;
        underrun <= 1'b1;
        if (under_cnt != '1) begin
          under_cnt <= under_cnt + 1'b1;
        end
      end
      if (in_rd_en) begin
        hold_buf <= in_data;
        buf_full <= 1'b1;
        idx      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pcie_rx_sample_unpacker.sv
// tb_pcie_rx_sample_unpacker
// Self-checking bench for pcie_rx_sample_unpacker (default parameters:
// 128-bit words, 16-bit samples, LSB-first, 16-bit underrun counter).
module tb_pcie_rx_sample_unpacker;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic         flush;
  logic         in_vld;
  logic [127:0] in_data;
  logic         in_rd_en;
  logic         smp_tick;
  logic         out_vld;
  logic [15:0]  out_data;
  logic         underrun;
  logic [15:0]  under_cnt;

  pcie_rx_sample_unpacker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .flush     (flush),
    .in_vld    (in_vld),
    .in_data   (in_data),
    .in_rd_en  (in_rd_en),
    .smp_tick  (smp_tick),
    .out_vld   (out_vld),
    .out_data  (out_data),
    .underrun  (underrun),
    .under_cnt (under_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic         fl;
    logic         vld;
    logic [127:0] data;
    logic         tk;
    logic         exp_rd;
    logic         exp_ov;
    logic [15:0]  exp_od;
    logic         exp_ur;
    logic [15:0]  exp_cnt;
  } vec_t;

  vec_t         tbl [12];
  logic [127:0] fq [$];
  logic         got_rd;
  int           total_checks;
  int           passed_checks;

  // Word whose lane i (LSB-first) holds base + i.
  function automatic logic [127:0] mkWord(input logic [15:0] base);
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      w[i*16 +: 16] = base + 16'(i);
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_checks++;
    if (act === exp) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One table row = one clock cycle: pop strobe checked before the edge,
  // registered outputs checked 1 time unit after it.
  task automatic applyStimulus(input vec_t v, input int n);
    enable   = v.en;
    flush    = v.fl;
    in_vld   = v.vld;
    in_data  = v.data;
    smp_tick = v.tk;
    #1;
    checkOutput($sformatf("row%0d in_rd_en", n), 128'(in_rd_en), 128'(v.exp_rd));
    @(posedge clk);
    #1;
    checkOutput($sformatf("row%0d out_vld", n), 128'(out_vld), 128'(v.exp_ov));
    checkOutput($sformatf("row%0d out_data", n), 128'(out_data), 128'(v.exp_od));
    checkOutput($sformatf("row%0d underrun", n), 128'(underrun), 128'(v.exp_ur));
    checkOutput($sformatf("row%0d under_cnt", n), 128'(under_cnt), 128'(v.exp_cnt));
  endtask

  // One cycle driven from the bench FIFO model (show-ahead queue).
  task automatic runCycle(input logic en, input logic fl, input logic tk);
    enable   = en;
    flush    = fl;
    smp_tick = tk;
    in_vld   = (fq.size() != 0);
    in_data  = (fq.size() != 0) ? fq[0] : '0;
    #1;
    got_rd = in_rd_en;
    @(posedge clk);
    if (got_rd && fq.size() != 0) void'(fq.pop_front());
    #1;
  endtask

  task automatic resetDut();
    rst_n    = 1'b0;
    enable   = 1'b0;
    flush    = 1'b0;
    smp_tick = 1'b0;
    in_vld   = 1'b0;
    in_data  = '0;
    fq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    got_rd        = 1'b0;

    // Load word 0 (lanes 0..7), prime, play lanes with one idle gap, then underrun.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, mkWord(16'h0000), 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 128'h0,           1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 128'h0,           1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 128'h0,           1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 16'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 128'h0,           1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 16'd0};
    for (int i = 2; i < 8; i++) begin
      tbl[i+3] = '{1'b1, 1'b0, 1'b0, 128'h0, 1'b1, 1'b0, 1'b1, 16'(i), 1'b0, 16'd0};
    end
    tbl[11] = '{1'b1, 1'b0, 1'b0, 128'h0,           1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'd1};

    // Reset state
    resetDut();
    checkOutput("reset out_vld", 128'(out_vld), 128'd0);
    checkOutput("reset out_data", 128'(out_data), 128'd0);
    checkOutput("reset underrun", 128'(underrun), 128'd0);
    checkOutput("reset under_cnt", 128'(under_cnt), 128'd0);
    in_vld = 1'b1;
    #1;
    checkOutput("disabled no pop", 128'(in_rd_en), 128'd0);
    in_vld = 1'b0;

    for (int n = 0; n < 12; n++) begin
      applyStimulus(tbl[n], n);
    end

    // Ticks in IDLE/PRIME are silent, then underruns in RUN and saturation.
    resetDut();
    for (int i = 0; i < 3; i++) begin
      runCycle(1'b1, 1'b0, 1'b1);
      checkOutput($sformatf("prime tick%0d out_vld", i), 128'(out_vld), 128'd0);
    end
    checkOutput("prime under_cnt", 128'(under_cnt), 128'd0);
    checkOutput("prime underrun", 128'(underrun), 128'd0);
    fq.push_back(mkWord(16'h1110));
    runCycle(1'b1, 1'b0, 1'b0);
    checkOutput("prime pop", 128'(got_rd), 128'd1);
    runCycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      runCycle(1'b1, 1'b0, 1'b1);
      checkOutput($sformatf("w1 lane%0d", i), 128'(out_data), 128'(16'h1110 + 16'(i)));
    end
    for (int i = 0; i < 3; i++) begin
      runCycle(1'b1, 1'b0, 1'b1);
      checkOutput($sformatf("under%0d out_vld", i), 128'(out_vld), 128'd1);
      checkOutput($sformatf("under%0d out_data", i), 128'(out_data), 128'd0);
    end
    checkOutput("underrun flag", 128'(underrun), 128'd1);
    checkOutput("under_cnt 3", 128'(under_cnt), 128'd3);
    for (int i = 0; i < 65532; i++) begin
      runCycle(1'b1, 1'b0, 1'b1);
    end
    checkOutput("under_cnt max", 128'(under_cnt), 128'hFFFF);
    runCycle(1'b1, 1'b0, 1'b1);
    checkOutput("under_cnt saturated", 128'(under_cnt), 128'hFFFF);
    checkOutput("saturated out_vld", 128'(out_vld), 128'd1);
    runCycle(1'b1, 1'b1, 1'b1);
    checkOutput("flush+tick out_vld", 128'(out_vld), 128'd0);
    checkOutput("flush underrun", 128'(underrun), 128'd0);
    checkOutput("flush under_cnt", 128'(under_cnt), 128'd0);

    // Two queued words, tick every cycle: 16 samples, refill on the 8th tick.
    resetDut();
    fq.push_back(mkWord(16'h2220));
    fq.push_back(mkWord(16'h3330));
    runCycle(1'b1, 1'b0, 1'b0);
    checkOutput("b2b first pop", 128'(got_rd), 128'd1);
    runCycle(1'b1, 1'b0, 1'b0);
    checkOutput("b2b no early pop", 128'(got_rd), 128'd0);
    for (int i = 0; i < 16; i++) begin
      runCycle(1'b1, 1'b0, 1'b1);
      checkOutput($sformatf("b2b tick%0d in_rd_en", i), 128'(got_rd), 128'(i == 7));
      checkOutput($sformatf("b2b tick%0d out_vld", i), 128'(out_vld), 128'd1);
      checkOutput($sformatf("b2b tick%0d out_data", i), 128'(out_data),
                  128'((i < 8) ? (16'h2220 + 16'(i)) : (16'h3330 + 16'(i - 8))));
    end
    checkOutput("b2b under_cnt", 128'(under_cnt), 128'd0);

    // Flush after 3 lanes: next word restarts at lane 0 via PRIME.
    resetDut();
    fq.push_back(mkWord(16'h4440));
    runCycle(1'b1, 1'b0, 1'b0);
    runCycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      runCycle(1'b1, 1'b0, 1'b1);
    end
    checkOutput("pre-flush lane2", 128'(out_data), 128'h4442);
    fq.push_back(mkWord(16'h5550));
    runCycle(1'b1, 1'b1, 1'b0);
    checkOutput("flush blocks pop", 128'(got_rd), 128'd0);
    runCycle(1'b1, 1'b0, 1'b1);
    checkOutput("post-flush pop", 128'(got_rd), 128'd1);
    checkOutput("post-flush prime tick", 128'(out_vld), 128'd0);
    checkOutput("post-flush under_cnt", 128'(under_cnt), 128'd0);
    runCycle(1'b1, 1'b0, 1'b0);
    runCycle(1'b1, 1'b0, 1'b1);
    checkOutput("post-flush lane0 vld", 128'(out_vld), 128'd1);
    checkOutput("post-flush lane0", 128'(out_data), 128'h5550);

    // Enable drop after 5 lanes; resume plays lanes 5..7 of the held word.
    resetDut();
    fq.push_back(mkWord(16'h6660));
    runCycle(1'b1, 1'b0, 1'b0);
    runCycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      runCycle(1'b1, 1'b0, 1'b1);
    end
    fq.push_back(mkWord(16'h7770));
    runCycle(1'b0, 1'b0, 1'b0);
    checkOutput("disable pop", 128'(got_rd), 128'd0);
    for (int i = 0; i < 2; i++) begin
      runCycle(1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("idle tick%0d out_vld", i), 128'(out_vld), 128'd0);
      checkOutput($sformatf("idle tick%0d pop", i), 128'(got_rd), 128'd0);
    end
    runCycle(1'b1, 1'b0, 1'b0);
    runCycle(1'b1, 1'b0, 1'b0);
    for (int i = 5; i < 8; i++) begin
      runCycle(1'b1, 1'b0, 1'b1);
      checkOutput($sformatf("resume lane%0d", i), 128'(out_data), 128'(16'h6660 + 16'(i)));
      checkOutput($sformatf("resume lane%0d pop", i), 128'(got_rd), 128'(i == 7));
    end
    runCycle(1'b1, 1'b0, 1'b1);
    checkOutput("resume next word", 128'(out_data), 128'h7770);

    // Reset mid-word clears the held sample.
    resetDut();
    checkOutput("re-reset out_data", 128'(out_data), 128'd0);
    checkOutput("re-reset out_vld", 128'(out_vld), 128'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
